// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bundle for the nibble-serial adder.
// The requester uses the master modport; the adder uses the slave modport.
interface nibble_serial_adder_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned Width = 4 * NIBBLES;

   logic             start;
   logic [Width-1:0] a;
   logic [Width-1:0] b;
   logic             busy;
   logic             done;
   logic [Width-1:0] sum;
   logic             carry;

   modport master (
      output start, a, b,
      input  busy, done, sum, carry
   );

   modport slave (
      input  start, a, b,
      output busy, done, sum, carry
   );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice per clock, LS nibble first, with the
// slice carry registered between cycles and a one-cycle done pulse at the end.
module nibble_serial_adder #(
   parameter int unsigned NIBBLES = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   nibble_serial_adder_if.slave bus
);
   localparam int unsigned Width = 4 * NIBBLES;
   localparam int unsigned IdxW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             c_q, c_d;
   logic [Width-1:0] a_q, a_d;
   logic [Width-1:0] b_q, b_d;
   logic [Width-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;

   logic [3:0] a_nib, b_nib;
   logic [4:0] nib_sum;

   // Select the active slice of the latched operands and add it with the chained carry.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (idx_q == IdxW'(k)) begin
            a_nib = a_q[4*k +: 4];
            b_nib = b_q[4*k +: 4];
         end
      end
      nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, c_q};
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      c_d     = c_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               c_d     = 1'b0;
               idx_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            for (int k = 0; k < NIBBLES; k++) begin
               if (idx_q == IdxW'(k)) begin
                  sum_d[4*k +: 4] = nib_sum[3:0];
               end
            end
            c_d = nib_sum[4];
            if (idx_q == LastIdx) begin
               carry_d = nib_sum[4];
               state_d = StDone;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         c_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   assign bus.busy  = (state_q == StRun);
   assign bus.done  = (state_q == StDone);
   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): directed table,
// multi-cycle corner sequences and randomized operands against a+b arithmetic.
module tb_nibble_serial_adder;
   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_carry;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nibble_serial_adder_if #(.NIBBLES(N)) bus ();

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation, scramble the operand inputs, and wait (bounded) for done.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] s, output logic c,
                         output int lat, output int busy_cycles);
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      step();
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      lat = 1;
      busy_cycles = 0;
      while (!bus.done && lat < 20) begin
         if (bus.busy) busy_cycles++;
         step();
         lat++;
      end
      s = bus.sum;
      c = bus.carry;
   endtask

   vec_t tbl[6];
   logic [W-1:0] s;
   logic         c;
   logic [W:0]   model;
   int           lat, bc, dones, gap;

   initial begin
      tbl[0] = '{a: 16'h1234, b: 16'h4321, exp_sum: 16'h5555, exp_carry: 1'b0};
      tbl[1] = '{a: 16'hFFFF, b: 16'h0001, exp_sum: 16'h0000, exp_carry: 1'b1};
      tbl[2] = '{a: 16'hFFFF, b: 16'hFFFF, exp_sum: 16'hFFFE, exp_carry: 1'b1};
      tbl[3] = '{a: 16'h8000, b: 16'h7FFF, exp_sum: 16'hFFFF, exp_carry: 1'b0};
      tbl[4] = '{a: 16'h0F0F, b: 16'h00F1, exp_sum: 16'h1000, exp_carry: 1'b0};
      tbl[5] = '{a: 16'h0000, b: 16'h0000, exp_sum: 16'h0000, exp_carry: 1'b0};

      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset then idle
      rst_n = 1'b0;
      bus.start = 1'b1;
      step();
      step();
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_sum", 32'(bus.sum), 0);
      check("reset_carry", 32'(bus.carry), 0);
      bus.start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_done", 32'(bus.done), 0);
      check("idle_sum", 32'(bus.sum), 0);

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, s, c, lat, bc);
         check($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].exp_sum));
         check($sformatf("tbl%0d_carry", i), 32'(c), 32'(tbl[i].exp_carry));
         check($sformatf("tbl%0d_latency", i), 32'(lat), 5);
         check($sformatf("tbl%0d_busy_cycles", i), 32'(bc), 4);
         check($sformatf("tbl%0d_busy_at_done", i), 32'(bus.busy), 0);
         step();
         check($sformatf("tbl%0d_done_pulse", i), 32'(bus.done), 0);
         check($sformatf("tbl%0d_sum_hold", i), 32'(bus.sum), 32'(tbl[i].exp_sum));
         check($sformatf("tbl%0d_carry_hold", i), 32'(bus.carry), 32'(tbl[i].exp_carry));
      end

      // start during RUN is ignored
      bus.start = 1'b1;
      bus.a = 16'h0F0F;
      bus.b = 16'h00F1;
      step();
      bus.start = 1'b0;
      step();
      bus.start = 1'b1;
      bus.a = 16'hAAAA;
      bus.b = 16'h5555;
      step();
      step();
      bus.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done) begin
            dones++;
            s = bus.sum;
            c = bus.carry;
         end
         step();
      end
      check("ignore_done_count", 32'(dones), 1);
      check("ignore_sum", 32'(s), 32'h1000);
      check("ignore_carry", 32'(c), 0);
      check("ignore_busy_end", 32'(bus.busy), 0);

      // Back-to-back with start held high
      bus.start = 1'b1;
      bus.a = 16'h0001;
      bus.b = 16'h0001;
      step();
      gap = 1;
      while (!bus.done && gap < 20) begin
         step();
         gap++;
      end
      check("b2b_first_latency", 32'(gap), 5);
      check("b2b_first_sum", 32'(bus.sum), 32'h0002);
      check("b2b_first_carry", 32'(bus.carry), 0);
      bus.a = 16'h7FFF;
      bus.b = 16'h0001;
      gap = 0;
      do begin
         step();
         gap++;
      end while (!bus.done && gap < 20);
      check("b2b_gap", 32'(gap), 5);
      check("b2b_second_sum", 32'(bus.sum), 32'h8000);
      check("b2b_second_carry", 32'(bus.carry), 0);
      bus.start = 1'b0;
      step();
      check("b2b_idle_done", 32'(bus.done), 0);
      check("b2b_idle_busy", 32'(bus.busy), 0);

      // Reset mid-operation
      bus.start = 1'b1;
      bus.a = 16'hFFFF;
      bus.b = 16'h0001;
      step();
      bus.start = 1'b0;
      step();
      rst_n = 1'b0;
      step();
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_done", 32'(bus.done), 0);
      check("midrst_sum", 32'(bus.sum), 0);
      check("midrst_carry", 32'(bus.carry), 0);
      rst_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus.done) dones++;
      end
      check("midrst_no_done", 32'(dones), 0);

      // Randomized operands against plain (W+1)-bit addition
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] x, y;
         x = W'($urandom);
         y = W'($urandom);
         if (i % 8 == 0) x = '1;
         model = {1'b0, x} + {1'b0, y};
         run_op(x, y, s, c, lat, bc);
         check($sformatf("rnd%0d_sum", i), 32'(s), 32'(model[W-1:0]));
         check($sformatf("rnd%0d_carry", i), 32'(c), 32'(model[W]));
         check($sformatf("rnd%0d_latency", i), 32'(lat), 5);
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
